// File: rtl/thermometer_to_binary_2s_complement.sv
// Serial sign + thermometer magnitude to parallel unsigned count and signed
// two's-complement result. One word per start pulse, result flagged by a
// one-cycle valid_out.
module thermometer_to_binary_2s_complement #(
  parameter int unsigned SERIAL_INPUT_LENGTH = 33
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start,
  input  logic                                        serial_in,
  output logic                                        valid_out,
  output logic [$clog2(SERIAL_INPUT_LENGTH-1)-1:0]    thermometer_sum_out,
  output logic [$clog2(SERIAL_INPUT_LENGTH-1):0]      thermometer_result_2scomp_out
);

  localparam int unsigned W = $clog2(SERIAL_INPUT_LENGTH - 1);
  // bit_counter value while the final data bit is being sampled
  localparam logic [W-1:0] LAST_BIT = W'(SERIAL_INPUT_LENGTH - 2);
  localparam logic [W-1:0] SUM_MAX  = {W{1'b1}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]   state, state_d;
  logic [W-1:0] bit_counter, bit_counter_d;
  logic [W:0]   sum_magnitude, sum_magnitude_d;
  logic         sign_q, sign_d;
  logic         valid_d;
  logic [W-1:0] sum_out_d;
  logic [W:0]   result_d;

  logic [W:0]   sum_next;
  logic [W-1:0] sum_sat;

  // Running count including the bit on the wire, and its saturated form
  assign sum_next = sum_magnitude + (W+1)'(serial_in);
  assign sum_sat  = sum_next[W] ? SUM_MAX : sum_next[W-1:0];

  // State and output registers, synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state                         <= IDLE;
      bit_counter                   <= '0;
      sum_magnitude                 <= '0;
      sign_q                        <= 1'b0;
      valid_out                     <= 1'b0;
      thermometer_sum_out           <= '0;
      thermometer_result_2scomp_out <= '0;
    end else begin
      state                         <= state_d;
      bit_counter                   <= bit_counter_d;
      sum_magnitude                 <= sum_magnitude_d;
      sign_q                        <= sign_d;
      valid_out                     <= valid_d;
      thermometer_sum_out           <= sum_out_d;
      thermometer_result_2scomp_out <= result_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d         = state;
    bit_counter_d   = bit_counter;
    sum_magnitude_d = sum_magnitude;
    sign_d          = sign_q;
    valid_d         = 1'b0;
    sum_out_d       = thermometer_sum_out;
    result_d        = thermometer_result_2scomp_out;

    case (state)
      IDLE, DONE: begin
        // DONE accepts start like IDLE so frames can run back to back
        if (start) begin
          sign_d          = serial_in;
          sum_magnitude_d = '0;
          bit_counter_d   = '0;
          state_d         = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        sum_magnitude_d = sum_next;
        if (bit_counter == LAST_BIT) begin
          // Last data bit: register results on this same edge
          sum_out_d = sum_sat;
          if (sign_q) begin
            result_d = (W+1)'(0) - sum_next;
          end else begin
            result_d = {1'b0, sum_sat};
          end
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          bit_counter_d = bit_counter + W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_thermometer_to_binary_2s_complement.sv
// Scoreboard bench: driver pushes expected results per frame, a negedge
// monitor pops on valid_out and checks held outputs on every other cycle.
module tb_thermometer_to_binary_2s_complement;

  localparam int unsigned N = 33;
  localparam int unsigned W = $clog2(N - 1);

  typedef struct {
    logic [W-1:0] sum;
    logic [W:0]   res;
    int unsigned  cyc;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         serial_in;
  logic         valid_out;
  logic [W-1:0] thermometer_sum_out;
  logic [W:0]   thermometer_result_2scomp_out;

  exp_t         q[$];
  int unsigned  cyc;
  int unsigned  checks;
  int unsigned  errors;
  bit           mon_en;
  logic [W-1:0] hold_sum;
  logic [W:0]   hold_res;

  thermometer_to_binary_2s_complement #(.SERIAL_INPUT_LENGTH(N)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .start                         (start),
    .serial_in                     (serial_in),
    .valid_out                     (valid_out),
    .thermometer_sum_out           (thermometer_sum_out),
    .thermometer_result_2scomp_out (thermometer_result_2scomp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: popcount, saturate positive side, exact negation on negative side
  function automatic exp_t model(input logic sign, input logic [N-2:0] data, input int unsigned vcyc);
    exp_t e;
    int m;
    int smax;
    int sat;
    int r;
    m = 0;
    for (int i = 0; i < N - 1; i++) m += int'(data[i]);
    smax = (1 << W) - 1;
    sat = (m > smax) ? smax : m;
    r = sign ? -m : sat;
    e.sum = W'(sat);
    e.res = (W+1)'(r);
    e.cyc = vcyc;
    return e;
  endfunction

  // Monitor: compare on valid, otherwise outputs must hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out) begin
        exp_t e;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid cyc=%0d sum=%0d res=%b required no valid", cyc,
                   thermometer_sum_out, thermometer_result_2scomp_out);
        end else begin
          e = q.pop_front();
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL valid_timing got cyc %0d required %0d", cyc, e.cyc);
          end
          checks++;
          if (thermometer_sum_out !== e.sum) begin
            errors++;
            $display("FAIL sum got %0d required %0d", thermometer_sum_out, e.sum);
          end
          checks++;
          if (thermometer_result_2scomp_out !== e.res) begin
            errors++;
            $display("FAIL result got %b required %b", thermometer_result_2scomp_out, e.res);
          end
          hold_sum = e.sum;
          hold_res = e.res;
        end
      end else begin
        checks++;
        if (thermometer_sum_out !== hold_sum || thermometer_result_2scomp_out !== hold_res) begin
          errors++;
          $display("FAIL hold cyc=%0d got sum %0d res %b required sum %0d res %b", cyc,
                   thermometer_sum_out, thermometer_result_2scomp_out, hold_sum, hold_res);
        end
      end
    end
  end

  // Caller is at posedge+#1; returns at posedge+#1 in the DONE cycle (or after abort)
  task automatic send(input logic sign, input logic [N-2:0] data, input int poke_at, input int abort_at);
    start     = 1'b1;
    serial_in = sign;
    q.push_back(model(sign, data, cyc + N));
    for (int k = 1; k <= N - 1; k++) begin
      @(posedge clk); #1;
      start     = (k == poke_at);
      serial_in = data[k-1];
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        start     = 1'b0;
        serial_in = 1'b0;
        q.delete();
        hold_sum  = '0;
        hold_res  = '0;
        return;
      end
    end
    @(posedge clk); #1;
    start     = 1'b0;
    serial_in = 1'b0;
  endtask

  task automatic idle(input int n);
    start     = 1'b0;
    serial_in = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [N-2:0] rand_data();
    logic [N-2:0] d;
    for (int i = 0; i < N - 1; i++) d[i] = 1'($urandom_range(0, 1));
    return d;
  endfunction

  function automatic logic [N-2:0] therm(input int k);
    logic [N-2:0] d;
    d = '0;
    for (int i = 0; i < k; i++) d[i] = 1'b1;
    return d;
  endfunction

  initial begin
    logic [N-2:0] alt;
    int waited;
    checks    = 0;
    errors    = 0;
    mon_en    = 1'b0;
    hold_sum  = '0;
    hold_res  = '0;
    rst       = 1'b1;
    start     = 1'b0;
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    send(1'b0, therm(5), 0, 0);               idle(3);   // +5
    send(1'b1, therm(8), 0, 0);               idle(3);   // -8
    send(1'b0, '0, 0, 0);                     idle(2);   // zero
    send(1'b1, '0, 0, 0);                     idle(2);   // negative zero
    send(1'b0, '1, 0, 0);                     idle(2);   // +32 saturates to +31
    send(1'b1, '1, 0, 0);                     idle(2);   // -32 exact
    for (int i = 0; i < N - 1; i++) alt[i] = (i % 2 == 1);
    send(1'b0, alt, 0, 0);                    idle(2);   // alternating, 16 ones
    send(1'b1, rand_data(), 7, 0);            idle(2);   // start poked mid-frame
    send(1'b0, therm(20), 0, 10);             idle(4);   // reset at data bit 10
    send(1'b0, therm(12), 0, 0);                         // back to back
    send(1'b1, therm(3), 0, 0);               idle(2);

    for (int f = 0; f < 24; f++) begin
      logic s;
      logic [N-2:0] d;
      s = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 1) == 1) ? rand_data() : therm(int'($urandom_range(0, N - 1)));
      send(s, d, (f % 5 == 0) ? int'($urandom_range(1, N - 1)) : 0, 0);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(0, 3)));
    end
    idle(3);

    waited = 0;
    while (q.size() != 0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending results required 0", q.size());
    end
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
